plm_port_initiator: RTL

//  Initiator-side controller for one port of a synchronous single-cycle-read dual-port BRAM macro
//  (CE/WE/WEM/A/D in, Q out one clock after an enabled read).

---
 rtl/plm_port_initiator_pkg.sv | 19 +
 rtl/plm_rsp_fifo.sv | 69 ++++++
 rtl/plm_port_initiator.sv | 91 +++++++++
 3 files changed

// File: rtl/plm_port_initiator_pkg.sv
// Shared definitions for the PLM bank port initiator: default bank
// geometry, BRAM read latency and the issue-side state encoding.
package plm_port_initiator_pkg;

  // Default PLM bank geometry (word address / data + mask width).
  localparam int PLM_ADDR_W  = 12;
  localparam int PLM_DATA_W  = 4;

  // BRAM Q appears one clock after an enabled read; rd_pend covers it.
  localparam int BRAM_RD_LAT = 1;

  // Issue side: IDLE has no read in the BRAM pipe, RDWAIT has one whose
  // data is on mem_q this cycle.
  typedef enum logic {
    ISSUE_IDLE   = 1'b0,
    ISSUE_RDWAIT = 1'b1
  } issue_state_e;

endpackage

// File: rtl/plm_rsp_fifo.sv
// Small circular response buffer. The head entry is a register, so the
// read data output has no combinational path from the push side.
module plm_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             not_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: write at tail on push, advance head on pop, wrap at DEPTH.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      entries_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers; reset empties the buffer and discards its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Overflow cannot happen when the caller respects its credits; catch it if it does.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count_q == CNT_W'(DEPTH)));
      assert (!(pop && count_q == '0));
    end
  end

  assign head_data = entries_q[rd_ptr_q];
  assign count     = count_q;
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/plm_port_initiator.sv
// Initiator for one PLM BRAM port: maps a valid/ready request stream onto
// CE/WE/WEM/A/D strobes and returns read data in order on a valid/ready
// response stream.
//
// Handshakes: a beat transfers on a rising edge where valid && ready are
// both 1; valid never depends on ready, and req_ready never depends on
// req_valid, req_we or rsp_ready (credits use the registered count only).
module plm_port_initiator
  import plm_port_initiator_pkg::*;
#(
  parameter int ADDR_W    = PLM_ADDR_W,
  parameter int DATA_W    = PLM_DATA_W,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wem,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  issue_state_e      state_q, state_d;
  logic              rd_pend;
  logic              fire;
  logic              credit_ok;
  logic [CNT_W:0]    inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;

  assign rd_pend = (state_q == ISSUE_RDWAIT);

  // Credits: buffered responses plus the read still inside the BRAM.
  always_comb begin
    inflight  = {1'b0, fifo_count} + (CNT_W + 1)'(rd_pend);
    credit_ok = (inflight < (CNT_W + 1)'(RSP_DEPTH));
    req_ready = !rst && credit_ok;
    fire      = req_valid && req_ready;
  end

  // Port strobes are a direct pass-through of the accepted request.
  always_comb begin
    mem_ce  = fire;
    mem_we  = fire && req_we;
    mem_wem = req_wmask;
    mem_a   = req_addr;
    mem_d   = req_wdata;
  end

  // Issue FSM: RDWAIT means mem_q carries read data this cycle.
  always_comb begin
    state_d = (fire && !req_we) ? ISSUE_RDWAIT : ISSUE_IDLE;
  end

  // Issue state register; reset drops any read still in the BRAM pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ISSUE_IDLE;
    else     state_q <= state_d;
  end

  assign fifo_pop = rsp_valid && rsp_ready;

  plm_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (mem_q),
    .pop       (fifo_pop),
    .head_data (rsp_rdata),
    .count     (fifo_count),
    .not_empty (rsp_valid)
  );

endmodule
